mem_ctrl: RTL and testbench

Load/store sequencer for the MEM stage of the 5-stage RV32 pipeline. It sits between exe_mem and mem_wb, in place of the pass-through memory stage. Non-memory results pass straight through. Loads and stores become one req/ack transaction on the data bus, and the pipeline is stalled until the transaction completes. The block handles byte-lane steering, byte enables, load sign/zero extension and bus-error reporting.

---
 rtl/mem_ctrl_if.sv | 17 +
 rtl/mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Data-bus req/ack handshake between mem_ctrl (master) and data memory (slave).
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, be, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata, err);
endinterface

// File: rtl/mem_ctrl.sv
// MEM-stage load/store sequencer: one req/ack bus transaction per load/store, pipeline stalled meanwhile.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses without a bus cycle.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif
`ifndef WRITE_DISABLE
`define WRITE_DISABLE 1'b0
`endif
`ifndef ZERO
`define ZERO 32'h0000_0000
`endif

module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    op_valid_i,
  input  logic                    op_we_i,
  input  logic [1:0]              op_size_i,
  input  logic                    op_unsigned_i,
  input  logic [ADDR_W-1:0]       op_addr_i,
  input  logic [DATA_W-1:0]       op_wdata_i,
  input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                    reg_we_i,
  input  logic [`RDATA_WIDTH-1:0] reg_wdata_i,
  output logic [`RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                    reg_we_o,
  output logic [`RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                    stall_o,
  output logic                    exc_o,
  output logic [ADDR_W-1:0]       exc_addr_o,
  mem_ctrl_if.master              bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;

  state_e            state_r;
  state_e            state_next_s;
  logic              misalign_s;
  logic              start_s;
  logic [1:0]        size_r;
  logic [1:0]        lane_r;
  logic              uns_r;
  logic [ADDR_W-1:0] fault_addr_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << {lane[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = data[{lane, 3'b000} +: 8];
    h = data[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = ((op_size_i == 2'b01) && op_addr_i[0]) ||
                      (op_size_i[1] && (op_addr_i[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign start_s = op_valid_i & ~misalign_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; ack is only honoured while a request is outstanding.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE:    state_next_s = start_s ? REQ : IDLE;
      REQ:     state_next_s = bus.ack ? DONE : REQ;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Bus request registers and captured response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.req      <= 1'b0;
      bus.we       <= 1'b0;
      bus.addr     <= {ADDR_W{1'b0}};
      bus.be       <= 4'b0000;
      bus.wdata    <= {DATA_W{1'b0}};
      size_r       <= 2'b00;
      lane_r       <= 2'b00;
      uns_r        <= 1'b0;
      fault_addr_r <= {ADDR_W{1'b0}};
      rdata_r      <= {DATA_W{1'b0}};
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            bus.req      <= 1'b1;
            bus.we       <= op_we_i;
            bus.addr     <= {op_addr_i[ADDR_W-1:2], 2'b00};
            bus.be       <= calc_be(op_size_i, op_addr_i[1:0]);
            bus.wdata    <= store_data(op_size_i, op_wdata_i);
            size_r       <= op_size_i;
            lane_r       <= op_addr_i[1:0];
            uns_r        <= op_unsigned_i;
            fault_addr_r <= op_addr_i;
          end
        end
        REQ: begin
          if (bus.ack) begin
            bus.req <= 1'b0;
            rdata_r <= bus.rdata;
            err_r   <= bus.err;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline-facing outputs; forced to their idle values while reset is asserted.
  always_comb begin
    stall_o     = 1'b0;
    exc_o       = 1'b0;
    exc_addr_o  = {ADDR_W{1'b0}};
    reg_waddr_o = reg_waddr_i;
    reg_we_o    = reg_we_i;
    reg_wdata_o = reg_wdata_i;
    if (!rst_n_i) begin
      reg_waddr_o = `ZERO_REG;
      reg_we_o    = `WRITE_DISABLE;
      reg_wdata_o = `ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (op_valid_i) begin
            reg_we_o = 1'b0;
            if (misalign_s) begin
              exc_o      = 1'b1;
              exc_addr_o = op_addr_i;
            end else begin
              stall_o = 1'b1;
            end
          end else begin
            stall_o = 1'b0;
          end
        end
        REQ: begin
          stall_o  = 1'b1;
          reg_we_o = 1'b0;
        end
        DONE: begin
          if (bus.we) begin
            reg_we_o = 1'b0;
          end else begin
            reg_we_o    = reg_we_i & ~err_r;
            reg_wdata_o = load_extend(rdata_r, size_r, lane_r, uns_r);
          end
          if (err_r) begin
            exc_o      = 1'b1;
            exc_addr_o = fault_addr_r;
          end else begin
            exc_o = 1'b0;
          end
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized loads/stores against a byte-level model.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_we, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic [`RADDR_WIDTH-1:0] reg_waddr, reg_waddr_o;
  logic        reg_we, reg_we_o;
  logic [`RDATA_WIDTH-1:0] reg_wdata, reg_wdata_o;
  logic        stall_o, exc_o;
  logic [31:0] exc_addr_o;
  int          checks = 0;
  int          errors = 0;

  mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .op_valid_i(op_valid), .op_we_i(op_we), .op_size_i(op_size), .op_unsigned_i(op_unsigned),
    .op_addr_i(op_addr), .op_wdata_i(op_wdata),
    .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .stall_o(stall_o), .exc_o(exc_o), .exc_addr_o(exc_addr_o),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Load result from the byte-lane rules: pick the addressed byte/half, then extend.
  function automatic logic [31:0] model_load(input int unsigned sz, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 4) return rd;
    if (sz == 1) v = (rd >> (8 * (addr % 4))) % 256;
    else         v = (rd >> (16 * ((addr / 2) % 2))) % 65536;
    if (!uns && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  // One complete load/store: detect cycle, waits+1 REQ cycles (ack on the last), DONE cycle.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic err, input logic [31:0] rd);
    logic [31:0] exp_addr, exp_wd, exp_ld;
    logic [3:0]  exp_be;
    logic [4:0]  rdst;
    logic        rwe;
    int          stalls;
    int unsigned sz;
    sz = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    exp_addr = addr & 32'hFFFF_FFFC;
    if (sz == 1) begin
      exp_be = 4'(1 << (addr % 4));
      exp_wd = (wd % 256) * 32'h0101_0101;
    end else if (sz == 2) begin
      exp_be = 4'(3 << (2 * ((addr / 2) % 2)));
      exp_wd = (wd % 65536) * 32'h0001_0001;
    end else begin
      exp_be = 4'hF;
      exp_wd = wd;
    end
    exp_ld = model_load(sz, uns, addr, rd);
    rdst   = 5'($urandom_range(1, 31));
    rwe    = 1'($urandom_range(0, 1));
    stalls = 0;
    @(negedge clk);
    op_valid = 1'b1; op_we = we; op_size = size; op_unsigned = uns; op_addr = addr; op_wdata = wd;
    reg_waddr = rdst; reg_we = rwe; reg_wdata = $urandom;
    bus.ack = 1'($urandom_range(0, 1)); bus.err = 1'b1; bus.rdata = $urandom;
    #1;
    if (stall_o === 1'b1) stalls++;
    checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL detect_we got %b want 0", reg_we_o); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL detect_req got %b want 0", bus.req); end
    for (int c = 0; c <= waits; c++) begin
      @(negedge clk);
      bus.ack   = 1'(c == waits);
      bus.err   = (c == waits) ? err : 1'b1;
      bus.rdata = (c == waits) ? rd : $urandom;
      #1;
      if (stall_o === 1'b1) stalls++;
      checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL req_high got %b want 1", bus.req); end
      checks++;
      if ({bus.we, bus.addr, bus.be} !== {we, exp_addr, exp_be}) begin
        errors++;
        $display("FAIL bus_ctrl got we=%b addr=%h be=%b want we=%b addr=%h be=%b",
                 bus.we, bus.addr, bus.be, we, exp_addr, exp_be);
      end
      if (we) begin
        checks++; if (bus.wdata !== exp_wd) begin errors++; $display("FAIL bus_wdata got %h want %h", bus.wdata, exp_wd); end
      end
      checks++;
      if (reg_we_o !== 1'b0 || exc_o !== 1'b0) begin
        errors++; $display("FAIL req_quiet got we=%b exc=%b want 0 0", reg_we_o, exc_o);
      end
    end
    @(negedge clk);
    bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = $urandom;
    #1;
    checks++;
    if (stalls != waits + 2 || stall_o !== 1'b0) begin
      errors++; $display("FAIL stall_cycles got %0d (done stall=%b) want %0d (0)", stalls, stall_o, waits + 2);
    end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL done_req got %b want 0", bus.req); end
    checks++;
    if (reg_we_o !== (!we && rwe && !err)) begin
      errors++; $display("FAIL done_we got %b want %b", reg_we_o, (!we && rwe && !err));
    end
    checks++; if (reg_waddr_o !== rdst) begin errors++; $display("FAIL done_waddr got %0d want %0d", reg_waddr_o, rdst); end
    if (!we) begin
      checks++; if (reg_wdata_o !== exp_ld) begin errors++; $display("FAIL load_data got %h want %h", reg_wdata_o, exp_ld); end
    end
    checks++;
    if (exc_o !== err || (err && exc_addr_o !== addr)) begin
      errors++; $display("FAIL done_exc got %b/%h want %b/%h", exc_o, exc_addr_o, err, addr);
    end
  endtask

  // One non-memory cycle with a stray ack on the bus; everything must pass straight through.
  task automatic idle_gap;
    @(negedge clk);
    op_valid = 1'b0; reg_waddr = 5'($urandom); reg_we = 1'($urandom); reg_wdata = $urandom;
    bus.ack = 1'($urandom_range(0, 1)); bus.err = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (bus.req !== 1'b0 || stall_o !== 1'b0 || exc_o !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got req=%b stall=%b exc=%b want 0 0 0", bus.req, stall_o, exc_o);
    end
    checks++;
    if (reg_we_o !== reg_we || reg_waddr_o !== reg_waddr || reg_wdata_o !== reg_wdata) begin
      errors++; $display("FAIL idle_pass got %b/%0d/%h want %b/%0d/%h",
                         reg_we_o, reg_waddr_o, reg_wdata_o, reg_we, reg_waddr, reg_wdata);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b1; op_we = 1'b1; op_size = 2'b10; op_unsigned = 1'b0;
    op_addr = 32'h40; op_wdata = 32'h55; reg_waddr = 5'd7; reg_we = 1'b1; reg_wdata = 32'h99;
    bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.req, bus.we, bus.addr, bus.be, bus.wdata} !== 70'd0) begin
      errors++; $display("FAIL reset_bus got req=%b addr=%h be=%b wdata=%h want zeros", bus.req, bus.addr, bus.be, bus.wdata);
    end
    checks++;
    if (stall_o !== 1'b0 || exc_o !== 1'b0 || exc_addr_o !== 32'd0) begin
      errors++; $display("FAIL reset_ctl got stall=%b exc=%b addr=%h want 0", stall_o, exc_o, exc_addr_o);
    end
    checks++;
    if (reg_waddr_o !== 5'd0 || reg_we_o !== 1'b0 || reg_wdata_o !== 32'd0) begin
      errors++; $display("FAIL reset_reg got %0d/%b/%h want 0/0/0", reg_waddr_o, reg_we_o, reg_wdata_o);
    end
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    op_valid = 1'b0; reg_waddr = 5'd5; reg_we = 1'b1; reg_wdata = 32'h0000_1234;
    #1;
    checks++;
    if (reg_waddr_o !== 5'd5 || reg_we_o !== 1'b1 || reg_wdata_o !== 32'h1234 || stall_o !== 1'b0) begin
      errors++; $display("FAIL passthrough got %0d/%b/%h stall=%b want 5/1/00001234 stall=0",
                         reg_waddr_o, reg_we_o, reg_wdata_o, stall_o);
    end
    repeat (4) idle_gap();
  endtask

  task automatic test_lb;
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 1'b0, 32'h80FF_0000);
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 1'b0, 32'h80FF_0000);
    run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 1'b0, 32'h9234_5678);
    idle_gap();
  endtask

  task automatic test_sh_waits;
    run_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 3, 1'b0, 32'h0);
    idle_gap();
  endtask

  task automatic test_bus_error;
    run_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
    idle_gap();
  endtask

  task automatic test_misaligned;
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_size = 2'b10; op_addr = 32'h41; reg_we = 1'b1;
    #1;
    checks++;
    if (exc_o !== 1'b1 || exc_addr_o !== 32'h41 || stall_o !== 1'b0 || reg_we_o !== 1'b0) begin
      errors++; $display("FAIL trap got exc=%b addr=%h stall=%b we=%b want 1 41 0 0", exc_o, exc_addr_o, stall_o, reg_we_o);
    end
    idle_gap();
`else
    run_op(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 0, 1'b0, 32'h1234_5678);
    idle_gap();
`endif
  endtask

  task automatic test_back_to_back;
    run_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    run_op(1'b1, 2'b00, 1'b0, 32'h305, 32'h0000_00A5, 0, 1'b0, 32'h0);
    run_op(1'b0, 2'b01, 1'b1, 32'h306, 32'h0, 2, 1'b0, 32'hF00D_8001);
    idle_gap();
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  size;
      logic [31:0] addr;
      size = 2'($urandom_range(0, 3));
      addr = $urandom & 32'h0000_FFFF;
`ifdef MEM_MISALIGN_TRAP_EN
      if (size == 2'b01) addr[0] = 1'b0;
      if (size[1]) addr[1:0] = 2'b00;
`endif
      run_op(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end
    idle_gap();
  endtask

  task automatic test_reset_mid_req;
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_size = 2'b10; op_addr = 32'h80; reg_we = 1'b1; bus.ack = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL midreq_pre got %b want 1", bus.req); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || stall_o !== 1'b0 || reg_we_o !== 1'b0) begin
      errors++; $display("FAIL midreq_reset got req=%b stall=%b we=%b want 0 0 0", bus.req, stall_o, reg_we_o);
    end
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.ack = 1'b1; bus.err = 1'b1;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL late_ack_req got %b want 0", bus.req); end
    @(negedge clk);
    bus.ack = 1'b0; bus.err = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0 || stall_o !== 1'b0 || exc_o !== 1'b0 || reg_we_o !== reg_we) begin
      errors++; $display("FAIL late_ack_idle got req=%b stall=%b exc=%b we=%b want 0 0 0 %b",
                         bus.req, stall_o, exc_o, reg_we_o, reg_we);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh_waits();
    test_bus_error();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
